// File: rtl/instr_sequencer_if.sv
// Bus bundle between the instruction sequencer and its surroundings.
// It carries two groups of signals:
//   - the fetch bus to program memory: instr_req, instr_addr, instr_valid, instr_data
//   - the register-bank / ALU control signals: ri/rj/rk selects, ri_data,
//     update, alusel, imm and imm_sel
// It also carries the status signals pcjmp and halted.
// The master modport is the sequencer side. The slave modport is the
// memory / register-bank side.
interface instr_sequencer_if #(
   parameter int PC_W = 8
);
   logic            instr_req;
   logic [PC_W-1:0] instr_addr;
   logic            instr_valid;
   logic [15:0]     instr_data;
   logic [4:0]      ri_select;
   logic [4:0]      rj_select;
   logic [4:0]      rk_select;
   logic [7:0]      ri_data;
   logic            update;
   logic [2:0]      alusel;
   logic [7:0]      imm;
   logic            imm_sel;
   logic            pcjmp;
   logic            halted;

   modport master (
      output instr_req, instr_addr,
      input  instr_valid, instr_data,
      output ri_select, rj_select, rk_select,
      input  ri_data,
      output update, alusel, imm, imm_sel, pcjmp, halted
   );

   modport slave (
      input  instr_req, instr_addr,
      output instr_valid, instr_data,
      input  ri_select, rj_select, rk_select,
      output ri_data,
      input  update, alusel, imm, imm_sel, pcjmp, halted
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer.
// It fetches 16-bit instruction words from program memory and decodes them
// into register-bank and ALU controls. It also handles LDI, JMP, JZ, NOP and
// HALT.
// Each instruction passes through FETCH -> DECODE -> EXEC -> WB. This takes
// 4 cycles, plus any cycles spent waiting for program memory.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - instr_sequencer_if.master, which carries:
//         fetch bus (instr_req/instr_addr out, instr_valid/instr_data in)
//         ri/rj/rk selects out, ri_data in
//         update, alusel, imm, imm_sel, pcjmp, halted out
module instr_sequencer #(
   parameter int PC_W = 8
) (
   input logic                clk,
   input logic                rst,
   instr_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      WB,
      HALT
   } state_t;

   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
   localparam logic [3:0] OP_JZ   = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t          state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_target;
   logic [15:0]     instr;
   logic            req_r;
   logic [PC_W-1:0] addr_r;
   logic            update_r;
   logic            pcjmp_r;
   logic            halted_r;
   logic [3:0]      op;

   assign op = instr[15:12];

   // The decoded controls are taken straight from the instruction latch.
   // The latch only changes on a FETCH capture. This keeps the controls
   // stable from DECODE through WB, and keeps them zero after reset.
   // JZ is the exception for ri_select: it reads its test register from
   // the rk field, bits [11:8].
   assign bus.rk_select = {1'b0, instr[11:8]};
   assign bus.ri_select = (op == OP_JZ) ? {1'b0, instr[11:8]} : {1'b0, instr[7:4]};
   assign bus.rj_select = {1'b0, instr[3:0]};
   assign bus.imm       = instr[7:0];
   assign bus.imm_sel   = (op == OP_LDI);
   assign bus.alusel    = op[3] ? 3'd0 : op[2:0];

   assign bus.instr_req  = req_r;
   assign bus.instr_addr = addr_r;
   assign bus.halted     = halted_r;

   // The write strobe and the jump pulse are masked by rst. This stops the
   // register bank from writing while reset is held during WB, even though
   // the registered strobe is already high in that cycle.
   assign bus.update = update_r & ~rst;
   assign bus.pcjmp  = pcjmp_r & ~rst;

   // Main sequencer.
   // The registered outputs are set on the transition into the state in
   // which they must be visible.
   // The next PC is computed in EXEC. It is committed in WB, and the next
   // fetch address is loaded in the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pc        <= '0;
         pc_target <= '0;
         instr     <= 16'h0000;
         req_r     <= 1'b0;
         addr_r    <= '0;
         update_r  <= 1'b0;
         pcjmp_r   <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               req_r  <= 1'b1;
               addr_r <= pc;
               state  <= FETCH;
            end
            FETCH: begin
               if (bus.instr_valid) begin
                  instr <= bus.instr_data;
                  req_r <= 1'b0;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (op == OP_HALT) begin
                  halted_r <= 1'b1;
                  state    <= HALT;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               pc_target <= pc + PC_W'(1);
               if (op[3] == 1'b0 || op == OP_LDI) begin
                  update_r <= 1'b1;
               end else if (op == OP_JMP) begin
                  pcjmp_r   <= 1'b1;
                  pc_target <= PC_W'(instr[7:0]);
               end else if (op == OP_JZ && bus.ri_data == 8'h00) begin
                  pcjmp_r   <= 1'b1;
                  pc_target <= PC_W'(instr[7:0]);
               end
               state <= WB;
            end
            WB: begin
               pc       <= pc_target;
               addr_r   <= pc_target;
               req_r    <= 1'b1;
               update_r <= 1'b0;
               pcjmp_r  <= 1'b0;
               state    <= FETCH;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// It uses a hand-sequenced program-memory responder and register read-back.
// Outputs are sampled on the falling edge. Inputs are driven on the falling
// edge.
module tb_instr_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   instr_sequencer_if #(.PC_W(8)) bus ();

   instr_sequencer #(.PC_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a fetch request and checks its address.
   // It then holds off instr_valid for dly cycles, and presents the word
   // plus ri_data. It returns at the falling edge inside DECODE.
   task automatic fetch_decode(input string tag, input logic [7:0] addr, input logic [15:0] word,
                               input int dly, input logic [7:0] rdata);
      int n = 0;
      while (bus.instr_req !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_req"}, bus.instr_req, 1);
      chk({tag, "_addr"}, bus.instr_addr, addr);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk({tag, "_wait_req"}, bus.instr_req, 1);
         chk({tag, "_wait_addr"}, bus.instr_addr, addr);
         chk({tag, "_wait_upd"}, bus.update, 0);
      end
      bus.instr_valid = 1'b1;
      bus.instr_data  = word;
      bus.ri_data     = rdata;
      @(negedge clk);
      chk({tag, "_dec_req"}, bus.instr_req, 0);
   endtask

   // Runs one non-HALT instruction and checks its controls in DECODE, EXEC
   // and WB.
   // A HALT word is left on instr_data with instr_valid high during DECODE
   // and EXEC, so that a spurious capture outside FETCH would be visible.
   // When rst_wb is set, reset is raised in WB and the strobes must stay low.
   task automatic run_instr(input string tag, input logic [7:0] addr, input logic [15:0] word,
                            input int dly, input logic [7:0] rdata,
                            input logic [4:0] e_rk, input logic [4:0] e_ri, input logic [4:0] e_rj,
                            input logic [2:0] e_alu, input logic [7:0] e_imm, input logic e_isel,
                            input logic e_upd, input logic e_jmp, input bit rst_wb);
      fetch_decode(tag, addr, word, dly, rdata);
      bus.instr_data = 16'hF000;
      chk({tag, "_rk"}, bus.rk_select, e_rk);
      chk({tag, "_ri"}, bus.ri_select, e_ri);
      chk({tag, "_rj"}, bus.rj_select, e_rj);
      chk({tag, "_alusel"}, bus.alusel, e_alu);
      chk({tag, "_imm"}, bus.imm, e_imm);
      chk({tag, "_imm_sel"}, bus.imm_sel, e_isel);
      chk({tag, "_dec_upd"}, bus.update, 0);
      @(negedge clk);
      chk({tag, "_exec_upd"}, bus.update, 0);
      chk({tag, "_exec_jmp"}, bus.pcjmp, 0);
      chk({tag, "_exec_rk"}, bus.rk_select, e_rk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      if (rst_wb) begin
         rst = 1'b1;
         #1;
         chk({tag, "_wb_rst_upd"}, bus.update, 0);
         chk({tag, "_wb_rst_jmp"}, bus.pcjmp, 0);
      end else begin
         chk({tag, "_wb_upd"}, bus.update, e_upd);
         chk({tag, "_wb_jmp"}, bus.pcjmp, e_jmp);
         chk({tag, "_wb_req"}, bus.instr_req, 0);
         chk({tag, "_wb_imm_sel"}, bus.imm_sel, e_isel);
      end
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr_data  = 16'h0000;
      bus.ri_data     = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst_req", bus.instr_req, 0);
      chk("rst_addr", bus.instr_addr, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_upd", bus.update, 0);
      chk("rst_jmp", bus.pcjmp, 0);
      chk("rst_rk", bus.rk_select, 0);
      chk("rst_imm", bus.imm, 0);
      chk("rst_imm_sel", bus.imm_sel, 0);
      rst = 1'b0;

      $display("[TB] LDI r3,5 from address 0");
      run_instr("ldi", 8'h00, 16'h8305, 0, 8'h00, 5'd3, 5'd0, 5'd5, 3'd0, 8'h05, 1'b1, 1'b1, 1'b0, 0);

      $display("[TB] ALU op 0x3124 with 3 wait cycles");
      run_instr("alu", 8'h01, 16'h3124, 3, 8'h00, 5'd1, 5'd2, 5'd4, 3'd3, 8'h24, 1'b0, 1'b1, 1'b0, 0);

      $display("[TB] JZ taken");
      run_instr("jz_t", 8'h02, 16'hA210, 0, 8'h00, 5'd2, 5'd2, 5'd0, 3'd0, 8'h10, 1'b0, 1'b0, 1'b1, 0);

      $display("[TB] JZ not taken");
      run_instr("jz_n", 8'h10, 16'hA210, 0, 8'h07, 5'd2, 5'd2, 5'd0, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] JMP to 0xFF");
      run_instr("jmp", 8'h11, 16'h90FF, 1, 8'h00, 5'd0, 5'd15, 5'd15, 3'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 0);

      $display("[TB] NOP at 0xFF wraps PC");
      run_instr("nop", 8'hFF, 16'hB000, 0, 8'h00, 5'd0, 5'd0, 5'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] reset during WB of LDI");
      run_instr("ldi_rst", 8'h00, 16'h8305, 0, 8'h00, 5'd3, 5'd0, 5'd5, 3'd0, 8'h05, 1'b1, 1'b1, 1'b0, 1);
      @(negedge clk);
      chk("ldi_rst_req", bus.instr_req, 0);
      chk("ldi_rst_addr", bus.instr_addr, 0);
      chk("ldi_rst_upd", bus.update, 0);
      rst = 1'b0;

      $display("[TB] HALT");
      fetch_decode("halt", 8'h00, 16'hF000, 0, 8'h00);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      chk("halt_halted", bus.halted, 1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_req", bus.instr_req, 0);
         chk("halt_upd", bus.update, 0);
      end
      chk("halt_still", bus.halted, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("halt_rst_halted", bus.halted, 0);
      chk("halt_rst_req", bus.instr_req, 0);
      rst = 1'b0;

      run_instr("post", 8'h00, 16'hB000, 0, 8'h00, 5'd0, 5'd0, 5'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("post_next_req", bus.instr_req, 1);
      chk("post_next_addr", bus.instr_addr, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
